tiny_nn_core_ctrl: RTL and testbench
====================================

Name: tiny_nn_core_ctrl

Overview:
- Command-driven sequencer for the tiny_nn_core datapath (fixed 4-wide x 2-high value/param arrays).
- Accepts host commands over a valid/ready interface: load a parameter, shift in a value, run an 8-element dot product, or run a single-row 4-element dot product with optional ReLU.
- Drives every core control strobe and returns the core's accumulate output over a valid/ready result interface.
- Sits between the host/DMA front-end and the core, one instance per core.

Parameters:
- ValArrayWidth, 4, columns per row; only 4 is supported, checked by an elaboration assertion.
- ValArrayHeight, 2, rows; only 2 is supported, checked by an elaboration assertion.
- CountWidth, 16, width of the completed-operation counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready.
- cmd_op_i  in  nn_cmd_op_e (2)  LoadParam / LoadVal / Dot8 / Dot4.
- cmd_idx_i  in  3  param index for LoadParam (= x*ValArrayHeight + y).
- cmd_row_i  in  1  row for LoadVal/Dot4.
- cmd_relu_i  in  1  apply ReLU (Dot4 only).
- cmd_data_i  in  fp_t  value or param data.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result accepted.
- res_o  out  fp_t  result (= core_accumulate_i).
- core_accumulate_i  in  fp_t  core accumulate output.
- val_o  out  fp_t  to core val input.
- val_shift_o  out  2  per-row value shift strobe.
- param_o  out  fp_t  to core param input.
- param_write_o  out  8  one-hot param write.
- mul_row_sel_o  out  1  row select (1 selects row 0, 0 selects row 1).
- mul_en_o  out  1  multiply-stage enable.
- accumulate_out_relu_o  out  1  ReLU on mode-1 final.
- accumulate_mode_0_en_o  out  2  mode-0 strobes.
- accumulate_mode_1_en_o  out  2  mode-1 strobes.
- Integration ties the remaining core inputs (loopback, mode 2, op_a/op_b/level-0 direct loads) to 0.

Behaviour:
- All core-side outputs are registered. Reset value of every output is 0, except cmd_ready_o, which is 1 in the first cycle after reset deasserts.
- Handshake: a command is accepted when cmd_valid_i & cmd_ready_o. cmd_ready_o = (state == Idle).
- LoadParam accepted at cycle t: at t+1, param_write_o = 1<<cmd_idx_i and param_o = data for one cycle. FSM stays Idle, so back-to-back loads run at 1 per cycle.
- LoadVal accepted at t: at t+1, val_shift_o[cmd_row_i] = 1 and val_o = data for one cycle. Back-to-back at 1 per cycle. Four shifts fill a row, entering at column 3 and moving toward 0.
- Dot8 accepted at t. FSM Idle -> Mul0 -> Mul1 -> Acc0 -> Acc1 -> Final -> Resp. Outputs per cycle (all other strobes 0):
  - t+1 Mul0: row_sel=1, mul_en=1.
  - t+2 Mul1: row_sel=0, mul_en=1, mode_0_en=01.
  - t+3 Acc0: row_sel=1, mode_0_en=01.
  - t+4 Acc1: row_sel=0, mode_0_en=01.
  - t+5 Final: mode_0_en=10.
  - t+6 Resp: res_valid_o=1.
- Dot4 accepted at t, row r, row_sel = ~r. FSM Idle -> Mul -> L0 -> Fin1 -> Resp:
  - t+1 Mul: mul_en=1.
  - t+2 L0: mode_1_en=01.
  - t+3 Fin1: mode_1_en=10, accumulate_out_relu_o = cmd_relu_i as latched at acceptance.
  - t+4 Resp.
- Resp state:
  - res_valid_o is held with res_o stable until res_ready_i.
  - On handshake the FSM returns to Idle in the next cycle; no command is accepted in the handshake cycle.
  - No core strobes are driven while in Resp.
- ReLU is ignored for Dot8; accumulate_out_relu_o stays 0.
- Counter: dot_count (internal, exposed as debug) increments by 1 on each result handshake and wraps modulo 2^CountWidth.
- rst_i asserted at any point (including mid-Dot or in Resp): the next cycle has all strobes 0, res_valid_o=0, state Idle, and the counter is cleared. The aborted operation produces no result.
- Loads pending in the output register when a Dot is accepted complete before Mul0. No hazard exists, because the registered strobe precedes the Mul0 cycle.

Decomposition:
- tiny_nn_pkg gains the nn_cmd_op_e enum (LoadParam=0, LoadVal=1, Dot8=2, Dot4=3) and the ctrl_state_e FSM enum.
- fp_t and FPZero are reused from the package.
- No sub-module; a single FSM plus output registers.

Test Plan:
- Reset: hold rst_i 3 cycles mid-Dot8 -> all strobes 0, res_valid_o=0, cmd_ready_o=1 the cycle after release.
- LoadParam idx 0..7, back-to-back, data=1.0..8.0 -> param_write_o 0x01,0x02,...,0x80 on consecutive cycles, param_o matching, cmd_ready_o never drops.
- With the core attached: rows loaded with values 1.0, params 1.0..8.0, Dot8 at t -> strobe sequence exactly as specified, res_valid_o at t+6, res_o=36.0.
- Dot4 row 1, relu=1, values 1.0, params -1.0,-2.0,-3.0,-4.0 -> row_sel=0, res_o=0.0 at t+4; same with relu=0 -> -10.0.
- Backpressure: res_ready_i low 5 cycles -> res_valid_o and res_o stable, cmd_ready_o=0, no core strobes; counter +1 only at handshake.
- Counter wrap with CountWidth=2: 5 Dot4 results -> count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/tiny_nn_pkg.sv
// Shared types for the tiny_nn core and its command sequencer.
// fp_t is signed Q8.8 fixed point; FPZero is its zero encoding.
package tiny_nn_pkg;

  typedef logic signed [15:0] fp_t;
  localparam fp_t FPZero = '0;

  typedef enum logic [1:0] {
    OpLoadParam = 2'd0,
    OpLoadVal   = 2'd1,
    OpDot8      = 2'd2,
    OpDot4      = 2'd3
  } nn_cmd_op_e;

  // Dot8 walks Mul0..Final, Dot4 walks Mul..Fin1; both end in Resp.
  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StMul0  = 4'd1,
    StMul1  = 4'd2,
    StAcc0  = 4'd3,
    StAcc1  = 4'd4,
    StFinal = 4'd5,
    StMul   = 4'd6,
    StL0    = 4'd7,
    StFin1  = 4'd8,
    StResp  = 4'd9
  } ctrl_state_e;

endpackage

// File: rtl/tiny_nn_core_ctrl.sv
// Command sequencer for one tiny_nn core: turns host commands into registered
// core strobes and returns the accumulate output as a held result.
module tiny_nn_core_ctrl
  import tiny_nn_pkg::*;
#(
  parameter int ValArrayWidth  = 4,
  parameter int ValArrayHeight = 2,
  parameter int CountWidth     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  nn_cmd_op_e            cmd_op_i,
  input  logic [2:0]            cmd_idx_i,
  input  logic                  cmd_row_i,
  input  logic                  cmd_relu_i,
  input  fp_t                   cmd_data_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output fp_t                   res_o,
  input  fp_t                   core_accumulate_i,
  output fp_t                   val_o,
  output logic [1:0]            val_shift_o,
  output fp_t                   param_o,
  output logic [7:0]            param_write_o,
  output logic                  mul_row_sel_o,
  output logic                  mul_en_o,
  output logic                  accumulate_out_relu_o,
  output logic [1:0]            accumulate_mode_0_en_o,
  output logic [1:0]            accumulate_mode_1_en_o,
  output ctrl_state_e           state_o,
  output logic [CountWidth-1:0] dot_count_o
);

  if (ValArrayWidth != 4) begin : g_bad_width
    $error("tiny_nn_core_ctrl: only ValArrayWidth=4 is supported");
  end
  if (ValArrayHeight != 2) begin : g_bad_height
    $error("tiny_nn_core_ctrl: only ValArrayHeight=2 is supported");
  end

  // Handshakes: a command transfers on a cycle where cmd_valid_i && cmd_ready_o;
  // a result transfers on a cycle where res_valid_o && res_ready_i. Once
  // raised, res_valid_o and res_o hold until that transfer.
  ctrl_state_e           r_state;
  logic                  r_row;
  logic                  r_relu;
  logic [CountWidth-1:0] r_dot_count;
  fp_t                   r_val;
  logic [1:0]            r_val_shift;
  fp_t                   r_param;
  logic [7:0]            r_param_write;
  logic                  r_row_sel;
  logic                  r_mul_en;
  logic                  r_out_relu;
  logic [1:0]            r_mode_0_en;
  logic [1:0]            r_mode_1_en;
  logic                  r_res_valid;

  logic                  w_accept;
  logic                  w_res_hs;
  logic                  w_row;
  logic                  w_relu;
  ctrl_state_e           w_state_nxt;
  fp_t                   w_val_nxt;
  logic [1:0]            w_val_shift_nxt;
  fp_t                   w_param_nxt;
  logic [7:0]            w_param_write_nxt;
  logic                  w_row_sel_nxt;
  logic                  w_mul_en_nxt;
  logic                  w_out_relu_nxt;
  logic [1:0]            w_mode_0_en_nxt;
  logic [1:0]            w_mode_1_en_nxt;
  logic                  w_res_valid_nxt;

  assign w_accept = cmd_valid_i && (r_state == StIdle);
  assign w_res_hs = (r_state == StResp) && res_ready_i;
  assign w_row    = w_accept ? cmd_row_i : r_row;
  assign w_relu   = w_accept ? cmd_relu_i : r_relu;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          case (cmd_op_i)
            OpDot8:  w_state_nxt = StMul0;
            OpDot4:  w_state_nxt = StMul;
            default: w_state_nxt = StIdle;
          endcase
        end
      end
      StMul0:  w_state_nxt = StMul1;
      StMul1:  w_state_nxt = StAcc0;
      StAcc0:  w_state_nxt = StAcc1;
      StAcc1:  w_state_nxt = StFinal;
      StFinal: w_state_nxt = StResp;
      StMul:   w_state_nxt = StL0;
      StL0:    w_state_nxt = StFin1;
      StFin1:  w_state_nxt = StResp;
      StResp:  w_state_nxt = res_ready_i ? StIdle : StResp;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Strobes are decoded from the state being entered, so each registered
  // output lines up with the cycle in which the FSM sits in that state.
  always_comb begin
    w_val_nxt         = FPZero;
    w_val_shift_nxt   = 2'b00;
    w_param_nxt       = FPZero;
    w_param_write_nxt = 8'h00;
    w_row_sel_nxt     = 1'b0;
    w_mul_en_nxt      = 1'b0;
    w_out_relu_nxt    = 1'b0;
    w_mode_0_en_nxt   = 2'b00;
    w_mode_1_en_nxt   = 2'b00;
    w_res_valid_nxt   = 1'b0;

    if (w_accept && (cmd_op_i == OpLoadParam)) begin
      w_param_write_nxt = 8'(1) << cmd_idx_i;
      w_param_nxt       = cmd_data_i;
    end
    if (w_accept && (cmd_op_i == OpLoadVal)) begin
      w_val_shift_nxt = 2'(1) << cmd_row_i;
      w_val_nxt       = cmd_data_i;
    end

    case (w_state_nxt)
      StMul0: begin
        w_row_sel_nxt = 1'b1;
        w_mul_en_nxt  = 1'b1;
      end
      StMul1: begin
        w_mul_en_nxt    = 1'b1;
        w_mode_0_en_nxt = 2'b01;
      end
      StAcc0: begin
        w_row_sel_nxt   = 1'b1;
        w_mode_0_en_nxt = 2'b01;
      end
      StAcc1:  w_mode_0_en_nxt = 2'b01;
      StFinal: w_mode_0_en_nxt = 2'b10;
      StMul: begin
        w_row_sel_nxt = ~w_row;
        w_mul_en_nxt  = 1'b1;
      end
      StL0: begin
        w_row_sel_nxt   = ~w_row;
        w_mode_1_en_nxt = 2'b01;
      end
      StFin1: begin
        w_row_sel_nxt   = ~w_row;
        w_mode_1_en_nxt = 2'b10;
        w_out_relu_nxt  = w_relu;
      end
      StResp:  w_res_valid_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= StIdle;
      r_row         <= 1'b0;
      r_relu        <= 1'b0;
      r_dot_count   <= '0;
      r_val         <= FPZero;
      r_val_shift   <= 2'b00;
      r_param       <= FPZero;
      r_param_write <= 8'h00;
      r_row_sel     <= 1'b0;
      r_mul_en      <= 1'b0;
      r_out_relu    <= 1'b0;
      r_mode_0_en   <= 2'b00;
      r_mode_1_en   <= 2'b00;
      r_res_valid   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_row         <= w_row;
      r_relu        <= w_relu;
      r_val         <= w_val_nxt;
      r_val_shift   <= w_val_shift_nxt;
      r_param       <= w_param_nxt;
      r_param_write <= w_param_write_nxt;
      r_row_sel     <= w_row_sel_nxt;
      r_mul_en      <= w_mul_en_nxt;
      r_out_relu    <= w_out_relu_nxt;
      r_mode_0_en   <= w_mode_0_en_nxt;
      r_mode_1_en   <= w_mode_1_en_nxt;
      r_res_valid   <= w_res_valid_nxt;
      if (w_res_hs) begin
        r_dot_count <= r_dot_count + CountWidth'(1);
      end
    end
  end

  assign cmd_ready_o            = (r_state == StIdle);
  assign res_valid_o            = r_res_valid;
  // The core holds its accumulator while we wait in Resp, so res_o is stable.
  assign res_o                  = r_res_valid ? core_accumulate_i : FPZero;
  assign val_o                  = r_val;
  assign val_shift_o            = r_val_shift;
  assign param_o                = r_param;
  assign param_write_o          = r_param_write;
  assign mul_row_sel_o          = r_row_sel;
  assign mul_en_o               = r_mul_en;
  assign accumulate_out_relu_o  = r_out_relu;
  assign accumulate_mode_0_en_o = r_mode_0_en;
  assign accumulate_mode_1_en_o = r_mode_1_en;
  assign state_o                = r_state;
  assign dot_count_o            = r_dot_count;

endmodule

// File: tb/tb_tiny_nn_core_ctrl.sv
// Bench for tiny_nn_core_ctrl with a small behavioural model of the core
// (value/param arrays, multiply stage, two accumulate paths) attached.
module tb_tiny_nn_core_ctrl;
  import tiny_nn_pkg::*;

  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  nn_cmd_op_e    cmd_op;
  logic [2:0]    cmd_idx;
  logic          cmd_row;
  logic          cmd_relu;
  fp_t           cmd_data;
  logic          res_valid;
  logic          res_ready;
  fp_t           res;
  fp_t           core_acc;
  fp_t           val;
  logic [1:0]    val_shift;
  fp_t           param;
  logic [7:0]    param_write;
  logic          row_sel;
  logic          mul_en;
  logic          out_relu;
  logic [1:0]    mode_0_en;
  logic [1:0]    mode_1_en;
  ctrl_state_e   state;
  logic [CW-1:0] dot_count;

  tiny_nn_core_ctrl #(.ValArrayWidth(4), .ValArrayHeight(2), .CountWidth(CW)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .cmd_valid_i            (cmd_valid),
    .cmd_ready_o            (cmd_ready),
    .cmd_op_i               (cmd_op),
    .cmd_idx_i              (cmd_idx),
    .cmd_row_i              (cmd_row),
    .cmd_relu_i             (cmd_relu),
    .cmd_data_i             (cmd_data),
    .res_valid_o            (res_valid),
    .res_ready_i            (res_ready),
    .res_o                  (res),
    .core_accumulate_i      (core_acc),
    .val_o                  (val),
    .val_shift_o            (val_shift),
    .param_o                (param),
    .param_write_o          (param_write),
    .mul_row_sel_o          (row_sel),
    .mul_en_o               (mul_en),
    .accumulate_out_relu_o  (out_relu),
    .accumulate_mode_0_en_o (mode_0_en),
    .accumulate_mode_1_en_o (mode_1_en),
    .state_o                (state),
    .dot_count_o            (dot_count)
  );

  // Core model: row_sel=1 picks row 0; param index = x*2 + y.
  fp_t m_val [2][4];
  fp_t m_param [8];
  fp_t m_mul [4];
  fp_t m_l0, m_l1, m_m1, m_acc;
  assign core_acc = m_acc;

  function automatic fp_t fmul(input fp_t a, input fp_t b);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    return fp_t'(p >>> 8);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 2; r++) for (int x = 0; x < 4; x++) m_val[r][x] <= FPZero;
      for (int k = 0; k < 8; k++) m_param[k] <= FPZero;
      for (int x = 0; x < 4; x++) m_mul[x] <= FPZero;
      m_l0 <= FPZero; m_l1 <= FPZero; m_m1 <= FPZero; m_acc <= FPZero;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (val_shift[r]) begin
          m_val[r][0] <= m_val[r][1];
          m_val[r][1] <= m_val[r][2];
          m_val[r][2] <= m_val[r][3];
          m_val[r][3] <= val;
        end
      end
      for (int k = 0; k < 8; k++) if (param_write[k]) m_param[k] <= param;
      if (mul_en) begin
        for (int x = 0; x < 4; x++)
          m_mul[x] <= fmul(m_val[row_sel ? 0 : 1][x], m_param[x*2 + (row_sel ? 0 : 1)]);
      end
      if (mul_en && mode_0_en == 2'b00) begin
        m_l0 <= FPZero;
        m_l1 <= FPZero;
      end
      if (mode_0_en[0]) begin
        m_l0 <= m_mul[0] + m_mul[1] + m_mul[2] + m_mul[3];
        m_l1 <= m_l1 + m_l0;
      end
      if (mode_0_en[1]) m_acc <= m_l1;
      if (mode_1_en[0]) m_m1 <= m_mul[0] + m_mul[1] + m_mul[2] + m_mul[3];
      if (mode_1_en[1]) m_acc <= (out_relu && m_m1 < 0) ? FPZero : m_m1;
    end
  end

  // Observed strobe bundle: {row_sel, mul_en, m0[1:0], m1[1:0], relu, res_valid, |pw, |vs, ready}
  logic [10:0] obs;
  assign obs = {row_sel, mul_en, mode_0_en, mode_1_en, out_relu, res_valid,
                |param_write, |val_shift, cmd_ready};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    nn_cmd_op_e op;
    logic [2:0] idx;
    logic       row;
    fp_t        data;
    logic [7:0] exp_pw;
    logic [1:0] exp_vs;
  } vec_t;

  vec_t        vecs [16];
  logic [10:0] seq [8];
  int          seq_n;

  task automatic load_param(input logic [2:0] idx, input fp_t data, input logic [7:0] exp_pw);
    cmd_valid = 1'b1; cmd_op = OpLoadParam; cmd_idx = idx; cmd_data = data;
    step();
    cmd_valid = 1'b0;
    chk("reload_pw", 32'(param_write), 32'(exp_pw));
    chk("reload_param", 32'(param), 32'(data));
  endtask

  // Issues a Dot, checks seq[0..seq_n-1] on the cycles after acceptance
  // (the last being the Resp cycle), then takes the result.
  task automatic run_dot(input string name, input nn_cmd_op_e op, input logic row,
                         input logic relu, input fp_t exp_res, input logic [CW-1:0] exp_cnt);
    cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_relu = relu; cmd_data = FPZero;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < seq_n; k++) begin
      if (k > 0) step();
      chk({name, "_strobes"}, 32'(obs), 32'(seq[k]));
    end
    chk({name, "_res"}, 32'(res), 32'(exp_res));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({name, "_after_hs"}, 32'(obs), 32'h001);
    chk({name, "_count"}, 32'(dot_count), 32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OpLoadParam; cmd_idx = 3'd0;
    cmd_row = 1'b0; cmd_relu = 1'b0; cmd_data = FPZero; res_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset_strobes", 32'(obs), 32'h001);
    chk("reset_val", 32'(val), 32'h0);
    chk("reset_param", 32'(param), 32'h0);
    chk("reset_res", 32'(res), 32'h0);
    chk("reset_count", 32'(dot_count), 32'h0);
    chk("reset_state", 32'(state), 32'(StIdle));

    // params 1.0..8.0 into idx 0..7, then four 1.0 shifts into each row
    for (int i = 0; i < 8; i++) begin
      vecs[i].op = OpLoadParam; vecs[i].idx = i[2:0]; vecs[i].row = 1'b0;
      vecs[i].data = fp_t'((i + 1) * 256); vecs[i].exp_pw = 8'(1 << i); vecs[i].exp_vs = 2'b00;
    end
    for (int i = 8; i < 16; i++) begin
      vecs[i].op = OpLoadVal; vecs[i].idx = 3'd0; vecs[i].row = (i >= 12);
      vecs[i].data = fp_t'(256); vecs[i].exp_pw = 8'h00;
      vecs[i].exp_vs = (i >= 12) ? 2'b10 : 2'b01;
    end
    for (int i = 0; i < 16; i++) begin
      cmd_valid = 1'b1; cmd_op = vecs[i].op; cmd_idx = vecs[i].idx;
      cmd_row = vecs[i].row; cmd_data = vecs[i].data;
      step();
      chk("load_pw", 32'(param_write), 32'(vecs[i].exp_pw));
      chk("load_vs", 32'(val_shift), 32'(vecs[i].exp_vs));
      chk("load_param", 32'(param), (vecs[i].op == OpLoadParam) ? 32'(vecs[i].data) : 32'h0);
      chk("load_val", 32'(val), (vecs[i].op == OpLoadVal) ? 32'(vecs[i].data) : 32'h0);
      chk("load_ready", 32'(cmd_ready), 32'h1);
    end
    cmd_valid = 1'b0;

    // Dot8 with relu requested (must be ignored): 16 + 20 = 36.0
    seq[0] = 11'b1_1_00_00_0_0_0_0_0;
    seq[1] = 11'b0_1_01_00_0_0_0_0_0;
    seq[2] = 11'b1_0_01_00_0_0_0_0_0;
    seq[3] = 11'b0_0_01_00_0_0_0_0_0;
    seq[4] = 11'b0_0_10_00_0_0_0_0_0;
    seq[5] = 11'b0_0_00_00_0_1_0_0_0;
    seq_n  = 6;
    run_dot("dot8", OpDot8, 1'b0, 1'b1, fp_t'(36 * 256), 2'd1);

    // Row 1 params become -1.0..-4.0
    load_param(3'd1, fp_t'(-256),  8'h02);
    load_param(3'd3, fp_t'(-512),  8'h08);
    load_param(3'd5, fp_t'(-768),  8'h20);
    load_param(3'd7, fp_t'(-1024), 8'h80);

    seq[0] = 11'b0_1_00_00_0_0_0_0_0;
    seq[1] = 11'b0_0_00_01_0_0_0_0_0;
    seq[2] = 11'b0_0_00_10_1_0_0_0_0;
    seq[3] = 11'b0_0_00_00_0_1_0_0_0;
    seq_n  = 4;
    run_dot("dot4_relu", OpDot4, 1'b1, 1'b1, FPZero, 2'd2);
    seq[2] = 11'b0_0_00_10_0_0_0_0_0;
    run_dot("dot4_norelu", OpDot4, 1'b1, 1'b0, fp_t'(-2560), 2'd3);

    // Backpressure with a load pending: nothing accepted until back in Idle
    cmd_valid = 1'b1; cmd_op = OpDot4; cmd_row = 1'b1; cmd_relu = 1'b0;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    cmd_valid = 1'b1; cmd_op = OpLoadParam; cmd_idx = 3'd7; cmd_data = fp_t'(-1024);
    for (int h = 0; h < 5; h++) begin
      chk("bp_strobes", 32'(obs), 32'h008);
      chk("bp_res", 32'(res), 32'(fp_t'(-2560)));
      chk("bp_count", 32'(dot_count), 32'd3);
      step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp_hs_no_accept", 32'(obs), 32'h001);
    chk("bp_count_wrap", 32'(dot_count), 32'd0);
    step();
    cmd_valid = 1'b0;
    chk("bp_late_accept", 32'(param_write), 32'h80);

    seq[2] = 11'b0_0_00_10_1_0_0_0_0;
    run_dot("dot4_again", OpDot4, 1'b1, 1'b1, FPZero, 2'd1);

    // Reset during Mul1 of a Dot8 aborts it with no result
    cmd_valid = 1'b1; cmd_op = OpDot8;
    step();
    cmd_valid = 1'b0;
    step();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_mid_strobes", 32'(obs), 32'h001);
      chk("rst_mid_count", 32'(dot_count), 32'd0);
      chk("rst_mid_state", 32'(state), 32'(StIdle));
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("post_rst_idle", 32'(obs), 32'h001);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
